// File: rtl/soc_io_pkg.sv
// Shared constants for the SoC I/O slave: page decode, register word-index bits,
// status bit layout and UART transmitter state encodings.
package soc_io_pkg;

  localparam int unsigned IO_PAGE_BIT   = 22;
  localparam int unsigned REG_LEDS      = 0;
  localparam int unsigned REG_UART_DAT  = 1;
  localparam int unsigned REG_UART_CTRL = 2;
  localparam int unsigned BUSY_BIT      = 9;
  localparam int unsigned LED_W         = 5;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned BYTE_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/soc_io_uart_tx.sv
// Transmit-only 8N1 UART: latches a byte on i_valid when idle (or on the final
// stop-bit cycle, allowing back-to-back frames) and shifts it out LSB first.
module uart_tx
  import soc_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_busy,
  output logic              o_txd
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = 3;

  uart_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0]  r_bit, w_bit_nxt;
  logic [BYTE_W-1:0] r_shreg, w_shreg_nxt;
  logic              r_txd, w_txd_nxt;
  logic              r_busy, w_busy_nxt;
  logic              w_cnt_end;

  assign w_cnt_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next state, counters and the registered line level for the next cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          w_state_nxt = ST_START;
          w_cnt_nxt   = '0;
          w_shreg_nxt = i_data;
        end
      end
      ST_START: begin
        if (w_cnt_end) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (w_cnt_end) begin
          w_cnt_nxt   = '0;
          w_shreg_nxt = {1'b0, r_shreg[BYTE_W-1:1]};
          if (r_bit == BIT_W'(BYTE_W - 1)) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (w_cnt_end) begin
          w_cnt_nxt = '0;
          if (i_valid) begin
            w_state_nxt = ST_START;
            w_shreg_nxt = i_data;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    case (w_state_nxt)
      ST_START: w_txd_nxt = 1'b0;
      ST_DATA:  w_txd_nxt = w_shreg_nxt[0];
      default:  w_txd_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign o_txd  = r_txd;
  assign o_busy = r_busy;

endmodule

// File: rtl/soc_io.sv
// Memory-mapped I/O slave: decodes the I/O page, holds the LED register, feeds
// the UART transmitter and returns read data with one registered cycle of latency.
module soc_io
  import soc_io_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter int unsigned BAUD        = 115_200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [3:0]        mem_wmask,
  input  logic              mem_rstrb,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [LED_W-1:0]  leds,
  output logic              txd
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

  logic [LED_W-1:0]  r_leds;
  logic [DATA_W-1:0] r_rdata;
  logic              w_io_sel;
  logic              w_wr;
  logic              w_leds_we;
  logic              w_uart_we;
  logic              w_busy;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              w_unused;

  assign w_io_sel  = mem_addr[IO_PAGE_BIT];
  // Register writes need the low byte lane enabled
  assign w_wr      = w_io_sel && (mem_wmask != 4'b0000) && mem_wmask[0];
  assign w_leds_we = w_wr && mem_addr[2 + REG_LEDS];
  assign w_uart_we = w_wr && mem_addr[2 + REG_UART_DAT];

  always_comb begin
    w_rdata_nxt = '0;
    if (mem_addr[2 + REG_LEDS]) begin
      w_rdata_nxt = w_rdata_nxt | DATA_W'(r_leds);
    end
    if (mem_addr[2 + REG_UART_CTRL]) begin
      w_rdata_nxt = w_rdata_nxt | (DATA_W'(w_busy) << BUSY_BIT);
    end
  end

  // Read data uses pre-write register values, so a same-cycle store is not seen
  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds  <= '0;
      r_rdata <= '0;
    end else begin
      if (w_leds_we) begin
        r_leds <= mem_wdata[LED_W-1:0];
      end
      if (w_io_sel && mem_rstrb) begin
        r_rdata <= w_rdata_nxt;
      end
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk    (clk),
    .reset  (reset),
    .i_data (mem_wdata[BYTE_W-1:0]),
    .i_valid(w_uart_we),
    .o_busy (w_busy),
    .o_txd  (txd)
  );

  assign mem_rdata = r_rdata;
  assign leds      = r_leds;

  assign w_unused = ^{mem_addr[DATA_W-1:IO_PAGE_BIT+1], mem_addr[IO_PAGE_BIT-1:5],
                      mem_addr[1:0], mem_wdata[DATA_W-1:BYTE_W], mem_wmask[3:1]};

endmodule
